// File: rtl/cpu_instr_decoder.sv
// Instruction fetch/decode sequencer: latches IR', encodes the ALU opcode and times exec pulses.
// Optional illegal-opcode trap (HALT until reset) is enabled by defining DECODER_ILLEGAL_TRAP_EN.
module cpu_instr_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        skipstatus,
  output logic [15:0] instruction,
  output logic [5:0]  decoder_encoded_opcode,
  output logic        exec1,
  output logic        exec2,
  output logic        aim,
  output logic        sim,
  output logic        squashed,
  output logic        illegal,
  output logic        busy
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC1  = 3'd2;
  localparam logic [2:0] ST_EXEC2  = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [5:0] OP_NOP       = 6'h3F;
  localparam logic [5:0] OP_MAX_LEGAL = 6'h38;
  localparam logic [5:0] OP_AIM       = 6'h0B;
  localparam logic [5:0] OP_SIM       = 6'h0C;

  function automatic logic op_in_range(input logic [5:0] field);
    return (field <= OP_MAX_LEGAL);
  endfunction

  function automatic logic op_is_multi(input logic [5:0] op);
    logic multi;
    case (op)
      6'h19, 6'h1B, 6'h21, 6'h22, 6'h24, 6'h26: multi = 1'b1;
      default:                                  multi = 1'b0;
    endcase
    return multi;
  endfunction

  function automatic logic [5:0] encode_opcode(input logic [5:0] field);
    logic [5:0] enc;
    if (op_in_range(field)) begin
      enc = field;
    end else begin
      enc = OP_NOP;
    end
    return enc;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [5:0]  opcode_q, opcode_d;
  logic        skip_pending_q, skip_pending_d;
  logic        squash_evt_s;

  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic exec1_q, exec1_d;
  logic exec2_q, exec2_d;
  logic aim_q, aim_d;
  logic sim_q, sim_d;
  logic squashed_q, squashed_d;
  logic illegal_q, illegal_d;

  // Sequencer next state: fetch handshake, decode/squash, execute timing and skip capture.
  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    opcode_d       = opcode_q;
    skip_pending_d = skip_pending_q;
    squash_evt_s   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          instr_d = instr_in;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        opcode_d = encode_opcode(instr_q[15:10]);
        if (skip_pending_q) begin
          // A squashed word never reaches execute, so it can never re-arm the skip.
          state_d        = ST_FETCH;
          skip_pending_d = 1'b0;
          squash_evt_s   = 1'b1;
        end
`ifdef DECODER_ILLEGAL_TRAP_EN
        else if (!op_in_range(instr_q[15:10])) begin
          state_d = ST_HALT;
        end
`endif
        else begin
          state_d = ST_EXEC1;
        end
      end
      ST_EXEC1: begin
        if (op_is_multi(opcode_q)) begin
          state_d = ST_EXEC2;
        end else begin
          state_d = ST_FETCH;
          if (skipstatus) begin
            skip_pending_d = 1'b1;
          end else begin
            skip_pending_d = skip_pending_q;
          end
        end
      end
      ST_EXEC2: begin
        state_d = ST_FETCH;
        if (skipstatus) begin
          skip_pending_d = 1'b1;
        end else begin
          skip_pending_d = skip_pending_q;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d        = ST_FETCH;
        skip_pending_d = 1'b0;
      end
    endcase
  end

  // Output next values are decoded from the next state so every output comes straight from a flop.
  always_comb begin
    ready_d    = (state_d == ST_FETCH);
    busy_d     = (state_d != ST_FETCH);
    exec1_d    = (state_d == ST_EXEC1);
    exec2_d    = (state_d == ST_EXEC2);
    aim_d      = exec1_d && (opcode_d == OP_AIM);
    sim_d      = exec1_d && (opcode_d == OP_SIM);
    squashed_d = squash_evt_s;
`ifdef DECODER_ILLEGAL_TRAP_EN
    illegal_d  = (state_d == ST_HALT);
`else
    illegal_d  = 1'b0;
`endif
  end

  // Architectural state and registered outputs; reset values describe an idle FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FETCH;
      instr_q        <= 16'h0000;
      opcode_q       <= OP_NOP;
      skip_pending_q <= 1'b0;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
      exec1_q        <= 1'b0;
      exec2_q        <= 1'b0;
      aim_q          <= 1'b0;
      sim_q          <= 1'b0;
      squashed_q     <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      opcode_q       <= opcode_d;
      skip_pending_q <= skip_pending_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
      exec1_q        <= exec1_d;
      exec2_q        <= exec2_d;
      aim_q          <= aim_d;
      sim_q          <= sim_d;
      squashed_q     <= squashed_d;
      illegal_q      <= illegal_d;
    end
  end

  assign instr_ready            = ready_q;
  assign busy                   = busy_q;
  assign instruction            = instr_q;
  assign decoder_encoded_opcode = opcode_q;
  assign exec1                  = exec1_q;
  assign exec2                  = exec2_q;
  assign aim                    = aim_q;
  assign sim                    = sim_q;
  assign squashed               = squashed_q;
  assign illegal                = illegal_q;

endmodule

// File: tb/tb_cpu_instr_decoder.sv
// Self-checking bench for cpu_instr_decoder: directed scenarios plus randomized traffic vs a timeline model.
module tb_cpu_instr_decoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        skipstatus;
  logic [15:0] instruction;
  logic [5:0]  decoder_encoded_opcode;
  logic        exec1, exec2, aim, sim, squashed, illegal, busy;

  int checks = 0;
  int errors = 0;

  cpu_instr_decoder dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .skipstatus(skipstatus), .instruction(instruction),
    .decoder_encoded_opcode(decoder_encoded_opcode), .exec1(exec1), .exec2(exec2),
    .aim(aim), .sim(sim), .squashed(squashed), .illegal(illegal), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs for one clock cycle.
  typedef struct packed {
    logic        ready, busy, e1, e2, aim, sim, sq, ill, halt, last;
    logic [5:0]  op;
    logic [15:0] ins;
  } rec_t;

  rec_t cur;
  rec_t tl[$];
  bit   skip;

  logic [5:0] multi_tab [6] = '{6'h19, 6'h1B, 6'h21, 6'h22, 6'h24, 6'h26};

`ifdef DECODER_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
  localparam int ILL_DIV = 40;
`else
  localparam bit TRAP = 1'b0;
  localparam int ILL_DIV = 8;
`endif

  function automatic rec_t reset_rec();
    rec_t r;
    r = '0;
    r.ready = 1'b1;
    r.op = 6'h3F;
    return r;
  endfunction

  function automatic rec_t idle_of(input rec_t p);
    rec_t r;
    r = '0;
    r.ready = 1'b1;
    r.op = p.op;
    r.ins = p.ins;
    return r;
  endfunction

  // Whole-instruction timeline produced at the moment a word is accepted.
  task automatic accept(input logic [15:0] w);
    rec_t d, x;
    logic [5:0] fld, op;
    bit legal, multi;
    fld = w[15:10];
    legal = (fld <= 6'h38);
    op = legal ? fld : 6'h3F;
    multi = 1'b0;
    foreach (multi_tab[k]) if (multi_tab[k] == op) multi = 1'b1;
    d = '0; d.busy = 1'b1; d.ins = w; d.op = cur.op;
    tl.push_back(d);
    if (skip) begin
      x = idle_of(d); x.op = op; x.sq = 1'b1;
      tl.push_back(x);
      skip = 1'b0;
    end else if (!legal && TRAP) begin
      x = '0; x.busy = 1'b1; x.ill = 1'b1; x.halt = 1'b1; x.ins = w; x.op = op;
      tl.push_back(x);
    end else begin
      x = '0; x.busy = 1'b1; x.e1 = 1'b1; x.ins = w; x.op = op;
      x.aim = (op == 6'h0B); x.sim = (op == 6'h0C); x.last = !multi;
      tl.push_back(x);
      if (multi) begin
        x.e1 = 1'b0; x.aim = 1'b0; x.sim = 1'b0; x.e2 = 1'b1; x.last = 1'b1;
        tl.push_back(x);
      end
    end
  endtask

  // Reference model: advances one cycle per rising edge, forced idle by reset.
  initial begin
    cur = reset_rec();
    skip = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cur = reset_rec();
        skip = 1'b0;
        tl.delete();
      end else begin
        if (cur.last && skipstatus) skip = 1'b1;
        if (cur.halt) begin
          cur = cur;
        end else if (cur.ready && instr_valid) begin
          accept(instr_in);
          cur = tl.pop_front();
        end else if (tl.size() > 0) begin
          cur = tl.pop_front();
        end else begin
          cur = idle_of(cur);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("ready", 16'(instr_ready), 16'(cur.ready));
      chk("busy", 16'(busy), 16'(cur.busy));
      chk("exec1", 16'(exec1), 16'(cur.e1));
      chk("exec2", 16'(exec2), 16'(cur.e2));
      chk("aim", 16'(aim), 16'(cur.aim));
      chk("sim", 16'(sim), 16'(cur.sim));
      chk("squashed", 16'(squashed), 16'(cur.sq));
      chk("illegal", 16'(illegal), 16'(cur.ill));
      chk("opcode", 16'(decoder_encoded_opcode), 16'(cur.op));
      chk("instruction", instruction, cur.ins);
    end
  end

  task automatic send(input logic [15:0] w, input logic sk);
    instr_in = w;
    instr_valid = 1'b1;
    skipstatus = sk;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [31:0] r;
  logic [5:0]  op;

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_in = 16'h0000; skipstatus = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 16'(instr_ready), 16'h1);
    chk("rst_opcode", 16'(decoder_encoded_opcode), 16'h3F);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 16'(instr_ready), 16'h1);

    // ADD 0x11, single cycle.
    send(16'h4400, 1'b0);
    chk("add_dec_ready", 16'(instr_ready), 16'h0);
    chk("add_instr", instruction, 16'h4400);
    @(negedge clk);
    chk("add_op", 16'(decoder_encoded_opcode), 16'h11);
    chk("model_add_op", 16'(cur.op), 16'h11);
    chk("add_exec1", 16'(exec1), 16'h1);
    chk("add_exec2", 16'(exec2), 16'h0);
    @(negedge clk);
    chk("add_ready_back", 16'(instr_ready), 16'h1);
    chk("add_exec1_end", 16'(exec1), 16'h0);

    // MUL 0x21, multi cycle.
    send(16'h8400, 1'b0);
    @(negedge clk);
    chk("mul_exec1", 16'(exec1), 16'h1);
    chk("model_mul_e1", 16'(cur.e1), 16'h1);
    @(negedge clk);
    chk("mul_exec2", 16'(exec2), 16'h1);
    chk("mul_exec1_low", 16'(exec1), 16'h0);
    chk("mul_ready_low", 16'(instr_ready), 16'h0);
    @(negedge clk);
    chk("mul_ready_back", 16'(instr_ready), 16'h1);
    chk("mul_exec2_end", 16'(exec2), 16'h0);

    // Skip sampled during exec1 of 0x5C00 squashes the next word.
    send(16'h5C00, 1'b1);
    @(negedge clk);
    chk("skip_src_exec1", 16'(exec1), 16'h1);
    @(negedge clk);
    skipstatus = 1'b0;
    send(16'h4400, 1'b0);
    @(negedge clk);
    chk("sq_pulse", 16'(squashed), 16'h1);
    chk("model_sq", 16'(cur.sq), 16'h1);
    chk("sq_no_exec1", 16'(exec1), 16'h0);
    chk("sq_opcode", 16'(decoder_encoded_opcode), 16'h11);
    chk("sq_ready", 16'(instr_ready), 16'h1);
    send(16'h4400, 1'b0);
    chk("sq_pulse_end", 16'(squashed), 16'h0);
    @(negedge clk);
    chk("after_sq_exec1", 16'(exec1), 16'h1);
    @(negedge clk);

    // AIM then SIM.
    send(16'h2C00, 1'b0);
    chk("aim_pre", 16'(aim), 16'h0);
    @(negedge clk);
    chk("aim_on", 16'(aim), 16'h1);
    chk("aim_sim_off", 16'(sim), 16'h0);
    @(negedge clk);
    chk("aim_off", 16'(aim), 16'h0);
    send(16'h3000, 1'b0);
    @(negedge clk);
    chk("sim_on", 16'(sim), 16'h1);
    chk("sim_aim_off", 16'(aim), 16'h0);
    @(negedge clk);
    chk("sim_off", 16'(sim), 16'h0);

    // Illegal opcode 0x3F field.
    send(16'hFC00, 1'b0);
    @(negedge clk);
    chk("ill_opcode", 16'(decoder_encoded_opcode), 16'h3F);
`ifdef DECODER_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      chk("halt_illegal", 16'(illegal), 16'h1);
      chk("halt_ready", 16'(instr_ready), 16'h0);
      chk("halt_exec1", 16'(exec1), 16'h0);
      instr_valid = 1'b1;
      instr_in = 16'h4400;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    pulse_reset();
`else
    chk("ill_exec1", 16'(exec1), 16'h1);
    chk("ill_flag", 16'(illegal), 16'h0);
    @(negedge clk);
    chk("ill_ready_back", 16'(instr_ready), 16'h1);
`endif

    // Reset during EXEC2 of MUL.
    send(16'h8400, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rmid_exec2_pre", 16'(exec2), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("rmid_exec2", 16'(exec2), 16'h0);
    chk("rmid_instr", instruction, 16'h0000);
    chk("rmid_opcode", 16'(decoder_encoded_opcode), 16'h3F);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmid_ready", 16'(instr_ready), 16'h1);
    chk("rmid_no_exec", 16'({exec1, exec2}), 16'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      r = $urandom();
      if ($urandom_range(0, 9) < 3) begin
        op = multi_tab[$urandom_range(0, 5)];
      end else if ($urandom_range(0, 7) == 0) begin
        op = r[20] ? 6'h0B : 6'h0C;
      end else if ($urandom_range(0, ILL_DIV - 1) == 0) begin
        op = 6'(6'h39 + $urandom_range(0, 6));
      end else begin
        op = 6'($urandom_range(0, 56));
      end
      instr_in = {op, r[9:0]};
      instr_valid = ($urandom_range(0, 2) != 0);
      skipstatus = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) begin
        instr_valid = 1'b0;
        pulse_reset();
      end else begin
        @(negedge clk);
      end
    end

    instr_valid = 1'b0;
    skipstatus = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_instr_decoder.md
CPU_INSTR_DECODER -- requirements
Module: cpu_instr_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the single clock, rst_n is the active-low asynchronous reset, and all state SHALL update on the rising edge of clk.
REQ-002 The port list SHALL be, clock and reset first:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_in  in  16  instruction word from memory.
- instr_valid  in  1  instr_in holds a valid word.
- instr_ready  out  1  block accepts a word this cycle.
- skipstatus  in  1  Q output of the SKIP flip-flop.
- instruction  out  16  latched instruction register (IR') driven to the ALU.
- decoder_encoded_opcode  out  6  encoded opcode driven to the ALU.
- exec1  out  1  first execute timing pulse.
- exec2  out  1  second execute pulse, multi-cycle ops only.
- aim  out  1  AIM instruction is executing.
- sim  out  1  SIM instruction is executing.
- squashed  out  1  current instruction is skipped.
- illegal  out  1  opcode field is out of range.
- busy  out  1  block is not in FETCH.

Function
REQ-003 States SHALL be FETCH, DECODE, EXEC1, EXEC2 and HALT, held in a registered state variable.
REQ-004 In FETCH, instr_ready SHALL be 1; in every other state it SHALL be 0.
REQ-005 A transfer SHALL occur on a clock edge where instr_valid and instr_ready are both 1; on a transfer, instruction SHALL load instr_in and the state SHALL go to DECODE.
REQ-006 If instr_valid is 0 in FETCH, the block SHALL hold FETCH with all outputs stable.
REQ-007 In DECODE, decoder_encoded_opcode SHALL register instruction[15:10] when that field is 0x00..0x38, and SHALL register 6'h3F (ALU default, output 0) otherwise.
REQ-008 decoder_encoded_opcode SHALL remain stable from the cycle after DECODE until the next DECODE.
REQ-009 Transitions out of DECODE SHALL be:
- skip_pending=1: go to FETCH, pulse squashed for 1 cycle, clear skip_pending, assert no exec.
- otherwise: go to EXEC1.
REQ-010 exec1 SHALL be 1 exactly for the one cycle the state is EXEC1.
REQ-011 The multi-cycle opcodes SHALL be 0x19 PUSH, 0x1B POP, 0x21 MUL, 0x22 MLS, 0x24 CALL and 0x26 RTN: EXEC1 SHALL go to EXEC2, which asserts exec2 for 1 cycle and then goes to FETCH.
REQ-012 All other opcodes SHALL go from EXEC1 to FETCH.
REQ-013 aim SHALL equal exec1 AND opcode==0x0B.
REQ-014 sim SHALL equal exec1 AND opcode==0x0C.
REQ-015 skipstatus SHALL be sampled in the last execute cycle (EXEC1 for single-cycle ops, EXEC2 for multi-cycle ops); if it is 1, skip_pending SHALL be set.
REQ-016 Latency: transfer at edge N -> opcode valid after edge N+1 -> exec1 high in cycle N+2 -> instr_ready high again in cycle N+3 (single-cycle op) or N+4 (multi-cycle op).
REQ-017 Back-to-back skips: a squashed instruction SHALL never set skip_pending, so a skip discards at most one instruction.
REQ-018 busy SHALL be 1 in every state except FETCH.

Reset
REQ-019 While rst_n=0, regardless of clk, the block SHALL force: state=FETCH, instruction=0, opcode=6'h3F, skip_pending=0, and exec1, exec2, aim, sim, squashed and illegal all 0.
REQ-020 Reset asserted mid-instruction (in EXEC1 or EXEC2) SHALL abort that instruction with no further exec pulse.
REQ-021 After rst_n rises, instr_ready SHALL be 1 on the first edge.

Configuration
REQ-022 With DECODER_ILLEGAL_TRAP_EN defined, an out-of-range opcode in DECODE SHALL:
- set illegal=1 and go to HALT;
- stay in HALT with illegal held at 1 and instr_ready=0 until reset.
REQ-023 Without DECODER_ILLEGAL_TRAP_EN, an out-of-range opcode SHALL execute as the 6'h3F no-op through EXEC1 and return to FETCH, with illegal tied to 0.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Single-cycle op: instr_in=0x4400 (ADD, 0x11), valid for 1 cycle -> opcode=0x11 after DECODE, one exec1 pulse, exec2=0, instr_ready back 3 cycles after the transfer.
- Multi-cycle op: instr_in=0x8400 (MUL, 0x21) -> exec1 pulse then exec2 pulse on consecutive cycles, instr_ready back 4 cycles after the transfer.
- Skip: skipstatus=1 during the exec1 of 0x5C00, next word 0x4400 -> squashed pulse, no exec1, opcode still updated to 0x11; the following word executes normally.
- AIM/SIM: 0x2C00 -> aim=1 only in the exec1 cycle; 0x3000 -> sim=1 only in the exec1 cycle.
- Illegal opcode: 0xFC00 -> with DECODER_ILLEGAL_TRAP_EN, illegal=1, HALT, ready=0 for 10 cycles; without it, opcode=0x3F, one exec1 pulse, illegal=0.
- Reset mid-op: rst_n low during EXEC2 of MUL -> exec2 drops immediately, instruction=0, opcode=0x3F, instr_ready=1 after release.
